fetch_controller: RTL and testbench

FETCH_CONTROLLER -- requirements
Module: fetch_controller

---
 rtl/cpu_pkg.sv | 10 +
 rtl/handshake_counter.sv | 19 +
 rtl/fetch_controller.sv | 98 +++++++++
 tb/tb_fetch_controller.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU front-end definitions: fetch controller state encoding.
package cpu_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DONE  = 2'd1,
        FAULT = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/handshake_counter.sv
// Free-running count of completed fetch-to-decode handshakes, wrapping at 2^WIDTH.
module handshake_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (en) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/fetch_controller.sv
// Instruction fetch controller: walks a PC through instruction memory and hands
// one registered word at a time to decode over a valid/ready handshake.
module fetch_controller
    import cpu_pkg::*;
#(
    parameter int WIDTH               = 32,
    parameter int INSTRACTION_NUMBERS = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pause,
    input  logic             branch_taken,
    input  logic [WIDTH-1:0] branch_target,
    input  logic [WIDTH-1:0] mem_data,
    output logic [WIDTH-1:0] mem_addr,
    input  logic             decode_ready,
    output logic [WIDTH-1:0] instr,
    output logic [WIDTH-1:0] instr_pc,
    output logic             instr_valid,
    output logic             done,
    output logic             fault,
    output logic [WIDTH-1:0] delivered_count
);

    // Handshake: a word transfers on any cycle where instr_valid && decode_ready.
    // The slot may be refilled the same cycle its word is accepted.
    localparam logic [WIDTH-1:0] DEPTH   = WIDTH'(INSTRACTION_NUMBERS);
    localparam logic [WIDTH-1:0] LAST_PC = WIDTH'(INSTRACTION_NUMBERS - 1);

    fetch_state_t     state;
    logic [WIDTH-1:0] pc;
    logic             slot_free;
    logic             handshake;

    assign mem_addr  = pc;
    assign slot_free = !instr_valid || decode_ready;
    assign handshake = instr_valid && decode_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= RUN;
            pc          <= '0;
            instr       <= '0;
            instr_pc    <= '0;
            instr_valid <= 1'b0;
            done        <= 1'b0;
            fault       <= 1'b0;
        end else begin
            case (state)
                RUN, DONE: begin
                    if (branch_taken) begin
                        // Flush wins over capture/pause; an out-of-range target traps.
                        instr_valid <= 1'b0;
                        done        <= 1'b0;
                        if (branch_target >= DEPTH) begin
                            state <= FAULT;
                            fault <= 1'b1;
                        end else begin
                            state <= RUN;
                            pc    <= branch_target;
                        end
                    end else if (state == DONE || pause) begin
                        if (decode_ready) begin
                            instr_valid <= 1'b0;
                        end
                    end else if (slot_free) begin
                        instr       <= mem_data;
                        instr_pc    <= pc;
                        instr_valid <= 1'b1;
                        if (pc == LAST_PC) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            pc <= pc + WIDTH'(1);
                        end
                    end
                end
                FAULT: begin
                    instr_valid <= 1'b0;
                end
                default: begin
                    state       <= FAULT;
                    fault       <= 1'b1;
                    done        <= 1'b0;
                    instr_valid <= 1'b0;
                end
            endcase
        end
    end

    handshake_counter #(.WIDTH(WIDTH)) u_handshake_counter (
        .clk   (clk),
        .rst   (rst),
        .en    (handshake),
        .count (delivered_count)
    );

endmodule

// File: tb/tb_fetch_controller.sv
// Bench for fetch_controller: behavioural model checked every cycle plus directed literal checks.
module tb_fetch_controller;

    localparam int W = 32;
    localparam int N = 16;

    localparam int M_RUN   = 0;
    localparam int M_DONE  = 1;
    localparam int M_FAULT = 2;

    logic         clk = 1'b0;
    logic         rst;
    logic         pause;
    logic         branch_taken;
    logic [W-1:0] branch_target;
    logic [W-1:0] mem_data;
    logic [W-1:0] mem_addr;
    logic         decode_ready;
    logic [W-1:0] instr;
    logic [W-1:0] instr_pc;
    logic         instr_valid;
    logic         done;
    logic         fault;
    logic [W-1:0] delivered_count;

    logic         mem_mode;
    int           checks   = 0;
    int           failures = 0;

    // model state
    bit           model_on = 1'b0;
    int           m_state;
    logic [W-1:0] m_pc, m_instr, m_instr_pc, m_count;
    bit           m_valid;

    fetch_controller #(.WIDTH(W), .INSTRACTION_NUMBERS(N)) dut (
        .clk             (clk),
        .rst             (rst),
        .pause           (pause),
        .branch_taken    (branch_taken),
        .branch_target   (branch_target),
        .mem_data        (mem_data),
        .mem_addr        (mem_addr),
        .decode_ready    (decode_ready),
        .instr           (instr),
        .instr_pc        (instr_pc),
        .instr_valid     (instr_valid),
        .done            (done),
        .fault           (fault),
        .delivered_count (delivered_count)
    );

    always #5 clk = ~clk;

    assign mem_data = mem_mode ? (32'h1000 + mem_addr * 7) : mem_addr;

    function automatic logic [W-1:0] word_at(logic [W-1:0] a);
        return mem_mode ? (32'h1000 + a * 7) : a;
    endfunction

    task automatic check(string name, logic [W-1:0] act, logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick(int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Compare against the model, then advance the model with the inputs held for the coming edge.
    always @(negedge clk) begin
        if (model_on) begin
            check("m_mem_addr", mem_addr, m_pc);
            check("m_valid", W'(instr_valid), W'(m_valid));
            check("m_done", W'(done), W'(m_state == M_DONE));
            check("m_fault", W'(fault), W'(m_state == M_FAULT));
            check("m_count", delivered_count, m_count);
            if (m_valid) begin
                check("m_instr", instr, m_instr);
                check("m_instr_pc", instr_pc, m_instr_pc);
            end
        end
        if (rst) begin
            model_on   = 1'b1;
            m_state    = M_RUN;
            m_pc       = '0;
            m_instr    = '0;
            m_instr_pc = '0;
            m_valid    = 1'b0;
            m_count    = '0;
        end else if (model_on && m_state != M_FAULT) begin
            if (m_valid && decode_ready) m_count = m_count + 1;
            if (branch_taken) begin
                m_valid = 1'b0;
                if (branch_target >= N) m_state = M_FAULT;
                else begin
                    m_pc    = branch_target;
                    m_state = M_RUN;
                end
            end else if (m_state == M_DONE || pause) begin
                if (decode_ready) m_valid = 1'b0;
            end else if (!m_valid || decode_ready) begin
                m_instr    = word_at(m_pc);
                m_instr_pc = m_pc;
                m_valid    = 1'b1;
                if (m_pc == N - 1) m_state = M_DONE;
                else m_pc = m_pc + 1;
            end
        end
    end

    task automatic check_reset_values(string tag);
        check({tag, "_mem_addr"}, mem_addr, 0);
        check({tag, "_instr"}, instr, 0);
        check({tag, "_instr_pc"}, instr_pc, 0);
        check({tag, "_valid"}, W'(instr_valid), 0);
        check({tag, "_done"}, W'(done), 0);
        check({tag, "_fault"}, W'(fault), 0);
        check({tag, "_count"}, delivered_count, 0);
    endtask

    initial begin
        rst = 1'b1; pause = 1'b0; branch_taken = 1'b0; branch_target = '0;
        decode_ready = 1'b0; mem_mode = 1'b0;
        tick(2);
        check_reset_values("reset");

        // sequential delivery, word k = k
        rst = 1'b0; decode_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tick(1);
            check("seq_instr", instr, W'(k));
            check("seq_instr_pc", instr_pc, W'(k));
            check("seq_count", delivered_count, W'(k));
        end

        // backpressure hold
        mem_mode = 1'b1; rst = 1'b1; tick(1); rst = 1'b0;
        tick(2);
        decode_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick(1);
            check("hold_instr", instr, 32'h1007);
            check("hold_instr_pc", instr_pc, 1);
            check("hold_mem_addr", mem_addr, 2);
        end
        decode_ready = 1'b1;
        tick(1);
        check("resume_instr", instr, 32'h100e);
        check("resume_count", delivered_count, 2);

        // branch flush while stalled
        decode_ready = 1'b0; branch_taken = 1'b1; branch_target = 9;
        tick(1);
        check("br_valid", W'(instr_valid), 0);
        check("br_mem_addr", mem_addr, 9);
        check("br_count", delivered_count, 2);
        branch_taken = 1'b0;
        tick(1);
        check("br_instr_pc", instr_pc, 9);
        check("br_instr", instr, 32'h103f);

        // pause: pending word delivered, no capture
        pause = 1'b1;
        tick(1);
        check("pause_hold_valid", W'(instr_valid), 1);
        decode_ready = 1'b1;
        tick(1);
        check("pause_drain_valid", W'(instr_valid), 0);
        check("pause_drain_count", delivered_count, 3);
        check("pause_mem_addr", mem_addr, 10);
        pause = 1'b0;
        tick(1);
        check("unpause_instr_pc", instr_pc, 10);

        // branch coinciding with handshake counts the word
        branch_taken = 1'b1; branch_target = 3;
        tick(1);
        check("brhs_count", delivered_count, 4);
        check("brhs_valid", W'(instr_valid), 0);
        check("brhs_mem_addr", mem_addr, 3);
        branch_taken = 1'b0;
        tick(1);

        // illegal target traps
        branch_taken = 1'b1; branch_target = 16;
        tick(1);
        check("fault_flag", W'(fault), 1);
        check("fault_valid", W'(instr_valid), 0);
        check("fault_mem_addr", mem_addr, 4);
        for (int i = 0; i < 5; i++) begin
            pause         = 1'($urandom_range(0, 1));
            decode_ready  = 1'($urandom_range(0, 1));
            branch_taken  = 1'($urandom_range(0, 1));
            branch_target = W'($urandom_range(0, 8));
            tick(1);
            check("fault_sticky", W'(fault), 1);
            check("fault_sticky_addr", mem_addr, 4);
        end

        // run to the end of memory
        mem_mode = 1'b0; rst = 1'b1; pause = 1'b0; branch_taken = 1'b0;
        decode_ready = 1'b1;
        tick(1);
        rst = 1'b0;
        tick(16);
        check("end_done", W'(done), 1);
        check("end_instr", instr, 15);
        check("end_count15", delivered_count, 15);
        tick(1);
        check("end_count16", delivered_count, 16);
        check("end_valid", W'(instr_valid), 0);
        tick(3);
        check("end_no_capture", W'(instr_valid), 0);
        check("end_mem_addr", mem_addr, 15);
        branch_taken = 1'b1; branch_target = 0;
        tick(1);
        check("restart_done", W'(done), 0);
        check("restart_mem_addr", mem_addr, 0);
        branch_taken = 1'b0;
        tick(1);
        check("restart_instr_valid", W'(instr_valid), 1);
        check("restart_instr_pc", instr_pc, 0);

        // reset mid-stream with pause and a pending word
        pause = 1'b1; decode_ready = 1'b0;
        tick(1);
        rst = 1'b1;
        tick(1);
        check_reset_values("midrst");
        rst = 1'b0; pause = 1'b0;

        // randomised traffic, model-checked every cycle
        mem_mode = 1'b1;
        for (int i = 0; i < 300; i++) begin
            rst           = ($urandom_range(0, 39) == 0);
            pause         = ($urandom_range(0, 3) == 0);
            decode_ready  = ($urandom_range(0, 2) != 0);
            branch_taken  = ($urandom_range(0, 7) == 0);
            branch_target = W'($urandom_range(0, 17));
            tick(1);
        end
        rst = 1'b1; branch_taken = 1'b0;
        tick(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
